// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared ALU: grants one operation at a time,
// registers operands for the ALU, captures its result and returns it.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   reqN_valid/ready     requester N (N=0,1) operation handshake
//   reqN_a/b/ctrl        requester N operands and ALU control code
//   rspN_valid/ready     response handshake back to requester N
//   rsp_result/flags     registered ALU result and {v,c,n,z} flags
//   alu_a/b/ctrl         operand register driven to the shared ALU
//   alu_result/flags     combinational outputs of the shared ALU
//   busy                 high whenever a transaction is in flight
//   FAIR (parameter)     1 = round-robin grant, 0 = requester 0 wins
module alu_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_ctrl,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_ctrl,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        owner_q;
  logic        ptr_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic [3:0]  ctrl_q;
  logic [31:0] res_q;
  logic [3:0]  flg_q;

  logic        sel;
  logic        gnt0;
  logic        gnt1;
  logic        accept;
  logic        done;

  assign alu_a      = opa_q;
  assign alu_b      = opb_q;
  assign alu_ctrl   = ctrl_q;
  assign rsp_result = res_q;
  assign rsp_flags  = flg_q;

  // sel names the requester that wins a tie; fixed mode always favours 0.
  always_comb begin
    sel  = FAIR ? ptr_q : 1'b0;
    gnt0 = req0_valid & (~req1_valid | ~sel);
    gnt1 = req1_valid & (~req0_valid | sel);
    done = owner_q ? rsp1_ready : rsp0_ready;
  end

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    accept     = 1'b0;
    busy       = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        req0_ready = gnt0 & ~reset;
        req1_ready = gnt1 & ~reset;
        accept     = gnt0 | gnt1;
        if (accept) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      ctrl_q  <= '0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= gnt1;
        opa_q   <= gnt1 ? req1_a : req0_a;
        opb_q   <= gnt1 ? req1_b : req0_b;
        ctrl_q  <= gnt1 ? req1_ctrl : req0_ctrl;
      end
      if (state_q == EXEC) begin
        res_q <= alu_result;
        flg_q <= alu_flags;
      end
      // Tie-break favours whoever did not just finish.
      if (state_q == RESP && done) begin
        ptr_q <= FAIR ? ~owner_q : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin and a fixed-priority
// instance share stimulus, each driving its own stand-in datapath ALU.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req1_valid = 1'b0;
  logic [31:0] req0_a = '0;
  logic [31:0] req0_b = '0;
  logic [3:0]  req0_ctrl = '0;
  logic [31:0] req1_a = '0;
  logic [31:0] req1_b = '0;
  logic [3:0]  req1_ctrl = '0;
  logic        rsp0_ready = 1'b0;
  logic        rsp1_ready = 1'b0;

  logic        f_req0_ready, f_req1_ready;
  logic        f_rsp0_valid, f_rsp1_valid;
  logic [31:0] f_rsp_result, f_alu_a, f_alu_b, f_alu_result;
  logic [3:0]  f_rsp_flags, f_alu_ctrl, f_alu_flags;
  logic        f_busy;

  logic        x_req0_ready, x_req1_ready;
  logic        x_rsp0_valid, x_rsp1_valid;
  logic [31:0] x_rsp_result, x_alu_a, x_alu_b, x_alu_result;
  logic [3:0]  x_rsp_flags, x_alu_ctrl, x_alu_flags;
  logic        x_busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Datapath ALU stand-in: flags are {overflow, carry, negative, zero}.
  function automatic logic [35:0] alu_f(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  c
  );
    logic [32:0] s;
    logic [31:0] r;
    logic        v;
    logic        cy;
    s = '0;
    r = '0;
    v = 1'b0;
    cy = 1'b0;
    case (c)
      4'b0000: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[31:0];
        cy = s[32];
        v  = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'b0001: begin
        s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r  = s[31:0];
        cy = s[32];
        v  = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      default: r = '0;
    endcase
    return {v, cy, r[31], (r == 32'd0), r};
  endfunction

  assign {f_alu_flags, f_alu_result} = alu_f(f_alu_a, f_alu_b, f_alu_ctrl);
  assign {x_alu_flags, x_alu_result} = alu_f(x_alu_a, x_alu_b, x_alu_ctrl);

  alu_arbiter #(.FAIR(1'b1)) u_fair (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp0_valid(f_rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(f_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(f_rsp_result), .rsp_flags(f_rsp_flags),
    .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_ctrl(f_alu_ctrl),
    .alu_result(f_alu_result), .alu_flags(f_alu_flags),
    .busy(f_busy)
  );

  alu_arbiter #(.FAIR(1'b0)) u_fix (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(x_req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(x_req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp0_valid(x_rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(x_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(x_rsp_result), .rsp_flags(x_rsp_flags),
    .alu_a(x_alu_a), .alu_b(x_alu_b), .alu_ctrl(x_alu_ctrl),
    .alu_result(x_alu_result), .alu_flags(x_alu_flags),
    .busy(x_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req0_valid = 1'b1;
    tick();
    tick();
    total++;
    if (f_req0_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_ready got %b want 0", f_req0_ready);
    end
    total++;
    if (f_busy !== 1'b0 || f_rsp0_valid !== 1'b0 || f_rsp1_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_ctl got busy=%b v0=%b v1=%b want 0 0 0",
               f_busy, f_rsp0_valid, f_rsp1_valid);
    end
    total++;
    if (f_rsp_result !== 32'd0 || f_rsp_flags !== 4'd0) begin
      bad++;
      $display("FAIL rst_rsp got %h/%b want 0/0", f_rsp_result, f_rsp_flags);
    end
    total++;
    if (f_alu_a !== 32'd0 || f_alu_b !== 32'd0 || f_alu_ctrl !== 4'd0) begin
      bad++;
      $display("FAIL rst_ops got %h %h %h want 0 0 0",
               f_alu_a, f_alu_b, f_alu_ctrl);
    end
    reset = 1'b0;
    req0_valid = 1'b0;
    tick();
  endtask

  task automatic test_add;
    rsp0_ready = 1'b1;
    req0_a = 32'd5;
    req0_b = 32'd7;
    req0_ctrl = 4'b0000;
    req0_valid = 1'b1;
    #1;
    total++;
    if (f_req0_ready !== 1'b1 || f_req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL add_grant got %b%b want 10", f_req0_ready, f_req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    total++;
    if (f_busy !== 1'b1 || f_alu_a !== 32'd5 || f_alu_b !== 32'd7
        || f_rsp0_valid !== 1'b0) begin
      bad++;
      $display("FAIL add_exec got busy=%b a=%0d b=%0d v=%b want 1 5 7 0",
               f_busy, f_alu_a, f_alu_b, f_rsp0_valid);
    end
    tick();
    total++;
    if (f_rsp0_valid !== 1'b1 || f_rsp1_valid !== 1'b0) begin
      bad++;
      $display("FAIL add_valid got %b%b want 10", f_rsp0_valid, f_rsp1_valid);
    end
    total++;
    if (f_rsp_result !== 32'd12 || f_rsp_flags !== 4'b0000) begin
      bad++;
      $display("FAIL add_res got %0d/%b want 12/0000",
               f_rsp_result, f_rsp_flags);
    end
    tick();
    total++;
    if (f_busy !== 1'b0 || f_rsp0_valid !== 1'b0) begin
      bad++;
      $display("FAIL add_done got busy=%b v=%b want 0 0",
               f_busy, f_rsp0_valid);
    end
    rsp0_ready = 1'b0;
  endtask

  task automatic test_sub;
    rsp1_ready = 1'b1;
    req1_a = 32'd3;
    req1_b = 32'd3;
    req1_ctrl = 4'b0001;
    req1_valid = 1'b1;
    #1;
    total++;
    if (f_req1_ready !== 1'b1 || f_req0_ready !== 1'b0) begin
      bad++;
      $display("FAIL sub_grant got %b%b want 01", f_req0_ready, f_req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    tick();
    total++;
    if (f_rsp1_valid !== 1'b1 || f_rsp0_valid !== 1'b0) begin
      bad++;
      $display("FAIL sub_valid got %b%b want 01", f_rsp0_valid, f_rsp1_valid);
    end
    total++;
    if (f_rsp_result !== 32'd0 || f_rsp_flags !== 4'b0101) begin
      bad++;
      $display("FAIL sub_res got %0d/%b want 0/0101",
               f_rsp_result, f_rsp_flags);
    end
    tick();
    rsp1_ready = 1'b0;
  endtask

  task automatic test_fair;
    logic e;
    req0_a = 32'd100;
    req0_b = 32'd1;
    req0_ctrl = 4'b0000;
    req1_a = 32'd200;
    req1_b = 32'd2;
    req1_ctrl = 4'b0000;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      e = i[0];
      total++;
      if (f_req0_ready !== ~e || f_req1_ready !== e) begin
        bad++;
        $display("FAIL rr_grant%0d got %b%b want %b%b",
                 i, f_req0_ready, f_req1_ready, ~e, e);
      end
      total++;
      if (x_req0_ready !== 1'b1 || x_req1_ready !== 1'b0) begin
        bad++;
        $display("FAIL fix_grant%0d got %b%b want 10",
                 i, x_req0_ready, x_req1_ready);
      end
      tick();
      tick();
      total++;
      if (f_rsp1_valid !== e
          || f_rsp_result !== (e ? 32'd202 : 32'd101)) begin
        bad++;
        $display("FAIL rr_rsp%0d got v1=%b r=%0d want %b %0d",
                 i, f_rsp1_valid, f_rsp_result, e, e ? 202 : 101);
      end
      total++;
      if (x_rsp0_valid !== 1'b1 || x_rsp_result !== 32'd101) begin
        bad++;
        $display("FAIL fix_rsp%0d got v0=%b r=%0d want 1 101",
                 i, x_rsp0_valid, x_rsp_result);
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  task automatic test_hold;
    req0_a = 32'd9;
    req0_b = 32'd6;
    req0_ctrl = 4'b0000;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp1_ready = 1'b1;
    #1;
    total++;
    if (f_req0_ready !== 1'b1) begin
      bad++;
      $display("FAIL hold_grant got %b want 1", f_req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    req0_a = 32'hdead_beef;
    tick();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (f_rsp0_valid !== 1'b1 || f_rsp_result !== 32'd15
          || f_req1_ready !== 1'b0 || f_busy !== 1'b1
          || f_alu_a !== 32'd9) begin
        bad++;
        $display("FAIL hold%0d got v=%b r=%0d rdy1=%b busy=%b a=%h",
                 k, f_rsp0_valid, f_rsp_result, f_req1_ready,
                 f_busy, f_alu_a);
      end
      tick();
    end
    rsp0_ready = 1'b1;
    req1_valid = 1'b0;
    tick();
    total++;
    if (f_busy !== 1'b0 || f_rsp0_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_done got busy=%b v=%b want 0 0",
               f_busy, f_rsp0_valid);
    end
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  task automatic test_reset_exec;
    req0_a = 32'd4;
    req0_b = 32'd4;
    req0_ctrl = 4'b0000;
    req0_valid = 1'b1;
    rsp0_ready = 1'b1;
    tick();
    req0_valid = 1'b0;
    total++;
    if (f_busy !== 1'b1 || f_alu_a !== 32'd4) begin
      bad++;
      $display("FAIL rx_exec got busy=%b a=%0d want 1 4", f_busy, f_alu_a);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (f_busy !== 1'b0 || f_rsp0_valid !== 1'b0 || f_rsp1_valid !== 1'b0
        || f_rsp_result !== 32'd0 || f_rsp_flags !== 4'd0) begin
      bad++;
      $display("FAIL rx_out got busy=%b v=%b%b r=%h f=%b want 0 00 0 0",
               f_busy, f_rsp0_valid, f_rsp1_valid, f_rsp_result,
               f_rsp_flags);
    end
    total++;
    if (f_alu_a !== 32'd0 || f_alu_ctrl !== 4'd0) begin
      bad++;
      $display("FAIL rx_ops got a=%h c=%h want 0 0", f_alu_a, f_alu_ctrl);
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    total++;
    if (f_req0_ready !== 1'b1 || f_req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL rx_ptr got %b%b want 10", f_req0_ready, f_req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    total++;
    if (f_rsp0_valid !== 1'b0 || f_busy !== 1'b0) begin
      bad++;
      $display("FAIL rx_idle got v=%b busy=%b want 0 0",
               f_rsp0_valid, f_busy);
    end
    rsp0_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_fair();
    test_hold();
    test_reset_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
